wght_fetch: RTL
===============

// Module: wght_fetch
// PURPOSE
//  Read-side sequencer for the URAM weight store: on a start command, streams COUNT weights from
//  consecutive addresses starting at BASE. Drives the memory's ren/raddr, absorbs the 1-cycle read
//  latency and presents words on a valid/ready stream. Sits between the spike/event scheduler and the
//  neuron accumulate pipeline; supports downstream backpressure without losing in-flight reads.
// PARAMETERS
//  RAM_DEPTH       10485                  words in weight store; addresses 0..RAM_DEPTH-1
//  BIT_WIDTH       31                     MSB index of a weight; word width = BIT_WIDTH+1, signed
//  RAM_ADDR_WIDTH  $clog2(RAM_DEPTH)      address width
//  CNT_WIDTH       16                     width of burst length
//  FIFO_DEPTH      4                      output buffer entries; power of 2, >=2
// PORTS
//  clk        in   1                one clock, all logic on posedge
//  rst        in   1                asynchronous, active-high reset
//  start      in   1                burst request; accepted only when busy==0
//  base_addr  in   RAM_ADDR_WIDTH   first address; must be < RAM_DEPTH
//  count      in   CNT_WIDTH        words to fetch; 0 allowed
//  busy       out  1                burst in progress
//  done       out  1                1-cycle pulse at burst end
//  mem_ren    out  1                memory read enable
//  mem_raddr  out  RAM_ADDR_WIDTH   memory read address
//  mem_rdat   in   BIT_WIDTH+1      signed memory data, valid the cycle after mem_ren
//  out_valid  out  1                out_data valid
//  out_ready  in   1                consumer accepts when valid&ready
//  out_data   out  BIT_WIDTH+1      signed weight
//  out_last   out  1                marks final word of burst (qualified by out_valid)
// BEHAVIOUR
//  - Reset: busy=0, done=0, mem_ren=0, mem_raddr=0, out_valid=0, out_last=0, out_data=0; FIFO empty,
//    in-flight read discarded; FSM->IDLE. Reset mid-burst abandons it: no done, no further reads.
//  - FSM: IDLE -> FETCH on start with count!=0 (latch base_addr, count; busy=1 next cycle).
//    IDLE + start with count==0: no reads, done=1 next cycle, busy stays 0.
//    FETCH -> DRAIN after the read for word count-1 is issued. DRAIN -> IDLE on handshake of out_last
//    word; done=1 and busy=0 in the following cycle. start while busy is ignored.
//  - Read issue: in FETCH, mem_ren=1 when (fifo_occupancy + inflight) < FIFO_DEPTH; never issues
//    a read whose data cannot be buffered. Max 1 read/cycle; no reads in IDLE/DRAIN.
//  - Addressing: word i uses base_addr+i, wrapping to (base_addr+i-RAM_DEPTH) when >= RAM_DEPTH.
//  - Latency: mem_rdat captured into FIFO the cycle after mem_ren; FIFO head drives out_data.
//    Best case first out_valid = 3 cycles after start (latch, ren, capture). Steady state with
//    out_ready=1: one word/cycle, no bubbles.
//  - Stream: out_valid/out_data/out_last hold stable while out_valid&!out_ready. Words emitted in
//    address order, exactly count words, out_last only on word count-1.
//  - FIFO full & capture in same cycle as pop: both allowed; occupancy unchanged.
//  - Counters sized CNT_WIDTH; count=2^CNT_WIDTH-1 must complete without overflow.
// CONFIGURATION
//  WGHT_FETCH_STALL_CNT_EN defined: adds port stall_cnt out 32 = cycles with out_valid&!out_ready
//    since last accepted start; cleared to 0 on accepted start and reset; saturates at 2^32-1.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 base=0,count=4,mem[i]=i+100,out_ready=1 -> raddr 0..3 on 4 consecutive cycles; out 100..103
//    back-to-back, out_last on 103, done 1 cycle after it, busy low with done.
//  2 count=0 -> no mem_ren ever, done pulse next cycle, busy never high.
//  3 base=RAM_DEPTH-2,count=4 -> raddr 10483,10484,0,1; data order matches.
//  4 count=16, out_ready toggling 1/0 and held 0 for 10 cycles -> no word lost/duplicated; mem_ren
//    stops once occupancy+inflight=4; out_data stable while stalled; stall_cnt (if enabled) = stall cycles.
//  5 start asserted again during burst with base=50 -> ignored; original stream unchanged.
//  6 rst pulsed mid-burst after 3 words -> outputs at reset values, no done; new start base=7,count=2
//    -> clean burst of mem[7],mem[8].

Source files
------------

// File: rtl/wght_fetch.sv
`default_nettype none
// ============================================================================
// Module   : wght_fetch
// Brief    : Read sequencer for the weight store. Streams `count` words from
//            consecutive, wrapping addresses onto a valid/ready output.
//            Optional macro WGHT_FETCH_STALL_CNT_EN adds the stall_cnt port.
// Revision : 1.0
// ============================================================================
module wght_fetch #(
    parameter int RAM_DEPTH      = 10485,
    parameter int BIT_WIDTH      = 31,
    parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
    parameter int CNT_WIDTH      = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [RAM_ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]      count,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_ren,
    output logic [RAM_ADDR_WIDTH-1:0] mem_raddr,
    input  logic signed [BIT_WIDTH:0] mem_rdat,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [BIT_WIDTH:0] out_data,
    output logic                      out_last
`ifdef WGHT_FETCH_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [RAM_ADDR_WIDTH-1:0]   r_addr;
    logic [CNT_WIDTH-1:0]        r_issue_left;
    logic [CNT_WIDTH-1:0]        r_out_left;
    logic                        r_inflight;
    logic                        r_done;
    logic signed [BIT_WIDTH:0]   r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]            r_wptr;
    logic [PTR_W-1:0]            r_rptr;
    logic [OCC_W-1:0]            r_occ;

    logic                        w_accept;
    logic                        w_space;
    logic                        w_pop;
    logic [OCC_W-1:0]            w_pending;

    assign w_accept  = start && (r_state == S_IDLE);
    // Words already captured plus the one still coming back from memory
    assign w_pending = r_occ + OCC_W'(r_inflight);
    assign w_space   = w_pending < OCC_W'(FIFO_DEPTH);

    assign out_valid = (r_occ != '0);
    assign w_pop     = out_valid && out_ready;
    assign out_last  = out_valid && (r_out_left == CNT_WIDTH'(1));
    assign out_data  = out_valid ? r_fifo[r_rptr] : '0;

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign mem_raddr = r_addr;

    always_comb begin
        w_state_nxt = r_state;
        mem_ren     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (count != '0)) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_space) begin
                    mem_ren = 1'b1;
                    if (r_issue_left == CNT_WIDTH'(1)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && out_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_issue_left <= '0;
            r_out_left   <= '0;
            r_inflight   <= 1'b0;
            r_done       <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_occ        <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= mem_ren;
            r_done     <= (w_accept && (count == '0)) ||
                          ((r_state == S_DRAIN) && w_pop && out_last);

            if (w_accept && (count != '0)) begin
                r_addr       <= base_addr;
                r_issue_left <= count;
                r_out_left   <= count;
            end else begin
                if (mem_ren) begin
                    r_addr       <= (r_addr == RAM_ADDR_WIDTH'(RAM_DEPTH - 1)) ?
                                    '0 : r_addr + RAM_ADDR_WIDTH'(1);
                    r_issue_left <= r_issue_left - CNT_WIDTH'(1);
                end
                if (w_pop) begin
                    r_out_left <= r_out_left - CNT_WIDTH'(1);
                end
            end

            if (r_inflight) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({r_inflight, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage needs no reset: out_data is masked whenever the buffer is empty
    always_ff @(posedge clk) begin
        if (r_inflight) begin
            r_fifo[r_wptr] <= mem_rdat;
        end
    end

`ifdef WGHT_FETCH_STALL_CNT_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_accept) begin
            r_stall <= '0;
        end else if (out_valid && !out_ready && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule
`default_nettype wire
